mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: number of consecutive blocked DMA request cycles after which DMA takes priority (range 1..15).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port cpu_req  in  1  CPU MEM-stage access request; held stable while cpu_stall=1.
REQ-005 SHALL have ports cpu_we in 1 (write), cpu_addr in 32, cpu_wdata in 32, cpu_size in 2, cpu_sign in 1: CPU access attributes.
REQ-006 SHALL have ports cpu_rdata out 32 (read data) and cpu_stall out 1 (CPU access not complete this cycle).
REQ-007 SHALL have ports dma_req in 1, dma_we in 1, dma_addr in 32, dma_wdata in 32: DMA requester; always word size, unsigned.
REQ-008 SHALL have ports dma_gnt out 1 (issue pulse), dma_rvalid out 1 (read data valid) and dma_rdata out 32.
REQ-009 SHALL have ports MEM_RDEN2, MEM_WE2 out 1; MEM_ADDR2, MEM_DIN2 out 32; MEM_SIZE out 2; MEM_SIGN out 1; MEM_DOUT2 in 32: memory data port, read data valid one cycle after MEM_RDEN2.

Function
REQ-010 SHALL implement FSM with states IDLE, CPU_RD, DMA_RD; new access issued only in IDLE.
REQ-011 In IDLE with no request: all MEM_* outputs 0, cpu_stall=0, dma_gnt=0.
REQ-012 Arbitration in IDLE: CPU wins when cpu_req=1, unless dma_req=1 and starve_cnt==STARVE_MAX, then DMA wins.
REQ-013 Winner's attributes SHALL drive MEM_* combinationally in the issue cycle; DMA drives MEM_SIZE=2'b10, MEM_SIGN=0.
REQ-014 CPU write issue: MEM_WE2=1, cpu_stall=0, stay IDLE (one-cycle completion).
REQ-015 CPU read issue: MEM_RDEN2=1, cpu_stall=1, next state CPU_RD.
REQ-016 CPU_RD: cpu_rdata=MEM_DOUT2, cpu_stall=0, MEM_* driven 0, next state IDLE.
REQ-017 DMA issue: dma_gnt=1 for exactly that cycle; write stays IDLE; read asserts MEM_RDEN2 and goes to DMA_RD.
REQ-018 DMA_RD: dma_rvalid=1, dma_rdata=MEM_DOUT2, next state IDLE; dma_rvalid=0 in all other states.
REQ-019 cpu_stall SHALL be 1 whenever cpu_req=1 and the CPU is not completing this cycle (loses arbitration, or port busy in CPU_RD/DMA_RD).
REQ-020 cpu_stall SHALL be 0 whenever cpu_req=0.
REQ-021 starve_cnt (4 bits): increments each cycle dma_req=1 without dma_gnt, saturating at STARVE_MAX; clears on dma_gnt or dma_req=0.
REQ-022 cpu_rdata and dma_rdata SHALL be 0 outside their data cycle.
REQ-023 Simultaneous cpu_req and dma_req with starve_cnt<STARVE_MAX: CPU served, starve_cnt increments.

Reset
REQ-024 RESET=1 SHALL immediately force state IDLE, starve_cnt=0, and all outputs 0, regardless of clk.
REQ-025 Reset during CPU_RD or DMA_RD SHALL abort the read: no cpu_stall release cycle, no dma_rvalid afterwards.
REQ-026 First issue after RESET deasserts SHALL occur at the first rising clk edge cycle with a request.

Verification
REQ-027 CPU write only, addr 0x1000, data 0xDEADBEEF -> same cycle MEM_WE2=1, MEM_ADDR2=0x1000, MEM_DIN2=0xDEADBEEF, cpu_stall=0.
REQ-028 CPU read 0x2000, memory returns 0x12345678 -> cycle 0 MEM_RDEN2=1, cpu_stall=1; cycle 1 cpu_rdata=0x12345678, cpu_stall=0.
REQ-029 CPU writes every cycle plus dma_req held, STARVE_MAX=4 -> CPU served cycles 0-3, dma_gnt=1 cycle 4 with cpu_stall=1, starve_cnt=0 after.
REQ-030 DMA read 0x3000 while CPU idle -> cycle 0 dma_gnt=1, MEM_SIZE=2'b10, MEM_SIGN=0; cycle 1 dma_rvalid=1 with MEM_DOUT2 data.
REQ-031 CPU read issued, RESET asserted mid-cycle before data cycle -> outputs 0 immediately, FSM IDLE, no dma_rvalid or cpu_rdata pulse afterwards.
REQ-032 cpu_req arriving during DMA_RD -> cpu_stall=1 that cycle, CPU issued next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory data port between the CPU MEM stage and a DMA
// requester. CPU has priority until DMA has been blocked STARVE_MAX cycles.
// Memory read data returns one cycle after MEM_RDEN2; only IDLE issues accesses.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DMA_RD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             dma_issue;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // State register; reset aborts any outstanding read.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Count consecutive blocked DMA request cycles, saturating at STARVE_MAX.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_issue) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Arbitration, next state and port outputs; everything forced low in reset.
    always_comb begin
        state_next = state;
        dma_issue  = 1'b0;
        cpu_rdata  = '0;
        cpu_stall  = 1'b0;
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = '0;
        MEM_RDEN2  = 1'b0;
        MEM_WE2    = 1'b0;
        MEM_ADDR2  = '0;
        MEM_DIN2   = '0;
        MEM_SIZE   = '0;
        MEM_SIGN   = 1'b0;
        if (!RESET) begin
            case (state)
                IDLE: begin
                    if (dma_req && (!cpu_req || starved)) begin
                        dma_issue = 1'b1;
                        dma_gnt   = 1'b1;
                        MEM_WE2   = dma_we;
                        MEM_RDEN2 = !dma_we;
                        MEM_ADDR2 = dma_addr;
                        MEM_DIN2  = dma_wdata;
                        MEM_SIZE  = 2'b10;
                        cpu_stall = cpu_req;
                        if (!dma_we) begin
                            state_next = DMA_RD;
                        end
                    end else if (cpu_req) begin
                        MEM_WE2   = cpu_we;
                        MEM_RDEN2 = !cpu_we;
                        MEM_ADDR2 = cpu_addr;
                        MEM_DIN2  = cpu_wdata;
                        MEM_SIZE  = cpu_size;
                        MEM_SIGN  = cpu_sign;
                        cpu_stall = !cpu_we;
                        if (!cpu_we) begin
                            state_next = CPU_RD;
                        end
                    end
                end
                CPU_RD: begin
                    cpu_rdata  = MEM_DOUT2;
                    state_next = IDLE;
                end
                DMA_RD: begin
                    dma_rvalid = 1'b1;
                    dma_rdata  = MEM_DOUT2;
                    cpu_stall  = cpu_req;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic compared against a pending-transaction reference model.
module tb_mem_port_arbiter;

    localparam int unsigned SM = 4;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sign = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [1:0]  cpu_size = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [31:0] MEM_ADDR2, MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic [31:0] mem_dout = '0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: outstanding reads and DMA blocked-cycle count.
    bit          m_cpu_pend, m_dma_pend;
    logic [31:0] m_cpu_addr, m_dma_addr;
    int unsigned m_starve;
    bit          e_stall;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
        .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h0000_2000) return 32'h1234_5678;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Memory: read data one cycle after MEM_RDEN2, junk otherwise.
    always_ff @(posedge clk) begin
        if (MEM_RDEN2) mem_dout <= rd_fn(MEM_ADDR2);
        else           mem_dout <= $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cpu_pend = 0; m_dma_pend = 0; m_starve = 0; e_stall = 0;
        m_cpu_addr = '0; m_dma_addr = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rden"},   32'(MEM_RDEN2),  32'd0);
        check({tag, " we"},     32'(MEM_WE2),    32'd0);
        check({tag, " addr"},   MEM_ADDR2,       32'd0);
        check({tag, " din"},    MEM_DIN2,        32'd0);
        check({tag, " size"},   32'(MEM_SIZE),   32'd0);
        check({tag, " sign"},   32'(MEM_SIGN),   32'd0);
        check({tag, " crdata"}, cpu_rdata,       32'd0);
        check({tag, " stall"},  32'(cpu_stall),  32'd0);
        check({tag, " gnt"},    32'(dma_gnt),    32'd0);
        check({tag, " rvalid"}, 32'(dma_rvalid), 32'd0);
        check({tag, " drdata"}, dma_rdata,       32'd0);
    endtask

    // Assert reset asynchronously, confirm outputs drop at once, release at a negedge.
    task automatic reset_pulse(input string tag);
        RESET = 1'b1;
        #1;
        check_all_zero(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        RESET = 1'b0;
        model_reset();
    endtask

    // One clock cycle: inputs already applied at negedge; check, then advance model.
    task automatic cycle();
        logic [31:0] e_addr, e_din, e_crd, e_drd;
        logic        e_rden, e_we, e_sign, e_gnt, e_rv;
        logic [1:0]  e_size;
        bit          dma_win, cpu_win;
        string       t;
        #1;
        e_addr = '0; e_din = '0; e_crd = '0; e_drd = '0;
        e_rden = 0; e_we = 0; e_sign = 0; e_gnt = 0; e_rv = 0; e_size = '0;
        dma_win = 0; cpu_win = 0;
        if (m_cpu_pend) begin
            e_crd   = rd_fn(m_cpu_addr);
            e_stall = 0;
        end else if (m_dma_pend) begin
            e_rv    = 1;
            e_drd   = rd_fn(m_dma_addr);
            e_stall = cpu_req;
        end else begin
            dma_win = dma_req && (!cpu_req || m_starve == SM);
            cpu_win = cpu_req && !dma_win;
            e_stall = cpu_req && !(cpu_win && cpu_we);
            if (dma_win) begin
                e_gnt = 1; e_we = dma_we; e_rden = !dma_we;
                e_addr = dma_addr; e_din = dma_wdata; e_size = 2'b10;
            end else if (cpu_win) begin
                e_we = cpu_we; e_rden = !cpu_we; e_addr = cpu_addr;
                e_din = cpu_wdata; e_size = cpu_size; e_sign = cpu_sign;
            end
        end
        t = $sformatf("c%0d", cyc);
        check({t, " rden"},   32'(MEM_RDEN2),  32'(e_rden));
        check({t, " we"},     32'(MEM_WE2),    32'(e_we));
        check({t, " addr"},   MEM_ADDR2,       e_addr);
        check({t, " din"},    MEM_DIN2,        e_din);
        check({t, " size"},   32'(MEM_SIZE),   32'(e_size));
        check({t, " sign"},   32'(MEM_SIGN),   32'(e_sign));
        check({t, " crdata"}, cpu_rdata,       e_crd);
        check({t, " stall"},  32'(cpu_stall),  32'(e_stall));
        check({t, " gnt"},    32'(dma_gnt),    32'(e_gnt));
        check({t, " rvalid"}, 32'(dma_rvalid), 32'(e_rv));
        check({t, " drdata"}, dma_rdata,       e_drd);
        @(posedge clk);
        if (!dma_req || dma_win)  m_starve = 0;
        else if (m_starve < SM)   m_starve = m_starve + 1;
        m_cpu_pend = cpu_win && !cpu_we;
        m_dma_pend = dma_win && !dma_we;
        if (cpu_win) m_cpu_addr = cpu_addr;
        if (dma_win) m_dma_addr = dma_addr;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #2;
        check_all_zero("por");
        @(posedge clk);
        @(negedge clk);
        RESET = 1'b0;

        // CPU write completes in its issue cycle.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h1000; cpu_wdata = 32'hDEAD_BEEF;
        cpu_size = 2'b10; cpu_sign = 0;
        #1;
        check("wr we",    32'(MEM_WE2),   32'd1);
        check("wr addr",  MEM_ADDR2,      32'h1000);
        check("wr din",   MEM_DIN2,       32'hDEAD_BEEF);
        check("wr stall", 32'(cpu_stall), 32'd0);
        cycle();

        // CPU read: stall in issue cycle, data the next.
        cpu_we = 0; cpu_addr = 32'h2000; cpu_size = 2'b01; cpu_sign = 1;
        #1;
        check("rd rden",  32'(MEM_RDEN2), 32'd1);
        check("rd stall", 32'(cpu_stall), 32'd1);
        cycle();
        #1;
        check("rd data",  cpu_rdata,      32'h1234_5678);
        check("rd stall1", 32'(cpu_stall), 32'd0);
        cycle();

        // Starvation: CPU writes every cycle, DMA waits STARVE_MAX cycles.
        cpu_we = 1; dma_req = 1; dma_we = 1; dma_addr = 32'h4000; dma_wdata = 32'hCAFE_0001;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) cpu_addr = 32'h5000 + 32'(i);
            #1;
            check($sformatf("stv gnt%0d", i),   32'(dma_gnt),   (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("stv stall%0d", i), 32'(cpu_stall), (i == 4) ? 32'd1 : 32'd0);
            cycle();
        end
        #1;
        check("stv cleared gnt", 32'(dma_gnt),   32'd0);
        check("stv cpu served",  32'(MEM_WE2),   32'd1);
        cycle();
        cpu_req = 0; dma_req = 0;
        cycle();

        // DMA read with CPU idle.
        dma_req = 1; dma_we = 0; dma_addr = 32'h3000;
        #1;
        check("dma gnt",  32'(dma_gnt),   32'd1);
        check("dma size", 32'(MEM_SIZE),  32'd2);
        check("dma sign", 32'(MEM_SIGN),  32'd0);
        check("dma rden", 32'(MEM_RDEN2), 32'd1);
        cycle();
        dma_req = 0;
        #1;
        check("dma rvalid", 32'(dma_rvalid), 32'd1);
        check("dma rdata",  dma_rdata,       rd_fn(32'h3000));
        cycle();

        // CPU request arriving during DMA_RD is stalled, then issued.
        dma_req = 1; dma_addr = 32'h6000;
        cycle();
        dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h7000;
        #1;
        check("busy stall", 32'(cpu_stall), 32'd1);
        cycle();
        #1;
        check("busy issue rden", 32'(MEM_RDEN2), 32'd1);
        check("busy issue addr", MEM_ADDR2,      32'h7000);
        cycle();
        cycle();
        cpu_req = 0;
        cycle();

        // Reset during an outstanding CPU read aborts it.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8000;
        #1;
        check("abort issue", 32'(MEM_RDEN2), 32'd1);
        reset_pulse("abort");
        cpu_req = 0;
        cycle();

        // Randomized traffic with occasional asynchronous reset.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse($sformatf("rrst%0d", n));
            end
            if (!e_stall) begin
                cpu_req   = ($urandom_range(0, 9) < 7);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
                cpu_size  = 2'($urandom_range(0, 3));
                cpu_sign  = $urandom_range(0, 1) == 1;
            end
            dma_req   = $urandom_range(0, 1) == 1;
            dma_we    = $urandom_range(0, 1) == 1;
            dma_addr  = $urandom;
            dma_wdata = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
